// File: rtl/pong_pkg.sv
// Shared playfield geometry, FSM state encodings and direction constants
// for the pong ball engine and its score counters.
package pong_pkg;

   localparam int ROWS = 32;
   localparam int COLS = 64;

   localparam logic [4:0] CENTRE_ROW = 5'd16;
   localparam logic [5:0] CENTRE_COL = 6'd32;
   localparam logic [4:0] TOP_ROW    = 5'(ROWS - 1);
   localparam logic [4:0] BOTTOM_ROW = 5'd0;
   localparam logic [5:0] LEFT_COL   = 6'd0;
   localparam logic [5:0] RIGHT_COL  = 6'(COLS - 1);

   localparam logic [3:0] SCORE_MAX  = 4'hF;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PLAY   = 2'd1;
   localparam logic [1:0] ST_SCORED = 2'd2;
   localparam logic [1:0] ST_OVER   = 2'd3;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/score_counter.sv
// Per-player score: 4-bit counter that saturates instead of wrapping and
// flags when the winning score has been reached.
module score_counter
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] score,
   output logic       win
);

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         score <= '0;
      end else if (inc && score != SCORE_MAX) begin
         score <= score + 4'd1;
      end
   end

   assign win = (score == 4'(WIN_SCORE));

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: moves the ball one cell per game step, reflects off walls and
// paddles, scores misses and runs the game FSM. Optional BALL_SPEEDUP_EN halves speed until 3 hits.
module ball_engine
   import pong_pkg::*;
#(
   parameter int SERVE_DELAY = 4,
   parameter int WIN_SCORE   = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick,
   input  logic            start,
   input  logic [ROWS-1:0] left_paddle,
   input  logic [ROWS-1:0] right_paddle,
   output logic [4:0]      ball_row,
   output logic [5:0]      ball_col,
   output logic            dir_up,
   output logic            dir_right,
   output logic [3:0]      score_left,
   output logic [3:0]      score_right,
   output logic            point_pulse,
   output logic            game_over
);

   localparam logic [3:0] SERVE_LAST = 4'(SERVE_DELAY - 1);

   logic [1:0] state;
   logic [3:0] serve_cnt;
   logic [4:0] next_row;
   logic       next_up;
   logic [5:0] next_col;
   logic       next_right;
   logic       miss_left;
   logic       miss_right;
   logic       advance;
   logic       step_play;
   logic       win_left;
   logic       win_right;
   logic       restart;
   logic       serve;

`ifdef BALL_SPEEDUP_EN
   logic [1:0] rally;
   logic       phase;
   logic       hit;

   // Slow rally: only every second tick moves the ball until three paddle hits.
   assign advance = tick && (phase || rally == 2'd3);
   assign hit     = step_play && (next_right != dir_right);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rally <= '0;
         phase <= 1'b0;
      end else if (state == ST_PLAY && tick) begin
         if (step_play && (miss_left || miss_right)) begin
            rally <= '0;
         end else if (hit && rally != 2'd3) begin
            rally <= rally + 2'd1;
         end
         if (rally != 2'd3) begin
            phase <= ~phase;
         end
      end else if (serve || restart) begin
         phase <= 1'b0;
      end
   end
`else
   assign advance = tick;
`endif

   assign step_play = (state == ST_PLAY) && advance;
   assign restart   = (state == ST_OVER) && start;
   assign serve     = (state == ST_SCORED) && tick && !(win_left || win_right)
                      && (serve_cnt == SERVE_LAST);
   assign game_over = (state == ST_OVER);

   // Paddle lookup uses the post-step row so a wall bounce and a paddle hit combine.
   always_comb begin
      next_row   = ball_row;
      next_up    = dir_up;
      next_col   = ball_col;
      next_right = dir_right;
      miss_left  = 1'b0;
      miss_right = 1'b0;

      if (dir_up == DIR_UP) begin
         if (ball_row == TOP_ROW) begin
            next_up  = DIR_DOWN;
            next_row = TOP_ROW - 5'd1;
         end else begin
            next_row = ball_row + 5'd1;
         end
      end else begin
         if (ball_row == BOTTOM_ROW) begin
            next_up  = DIR_UP;
            next_row = BOTTOM_ROW + 5'd1;
         end else begin
            next_row = ball_row - 5'd1;
         end
      end

      if (dir_right == DIR_LEFT && ball_col == LEFT_COL + 6'd1) begin
         if (left_paddle[next_row]) begin
            next_right = DIR_RIGHT;
            next_col   = LEFT_COL + 6'd2;
         end else begin
            next_col  = LEFT_COL;
            miss_left = 1'b1;
         end
      end else if (dir_right == DIR_RIGHT && ball_col == RIGHT_COL - 6'd1) begin
         if (right_paddle[next_row]) begin
            next_right = DIR_LEFT;
            next_col   = RIGHT_COL - 6'd1 - 6'd1;
         end else begin
            next_col   = RIGHT_COL;
            miss_right = 1'b1;
         end
      end else if (dir_right == DIR_RIGHT) begin
         next_col = ball_col + 6'd1;
      end else begin
         next_col = ball_col - 6'd1;
      end
   end

   // The serve heads toward whoever conceded; the frozen column says who that was.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         ball_row    <= CENTRE_ROW;
         ball_col    <= CENTRE_COL;
         dir_up      <= DIR_UP;
         dir_right   <= DIR_RIGHT;
         serve_cnt   <= '0;
         point_pulse <= 1'b0;
      end else begin
         point_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (advance) begin
                  ball_row  <= next_row;
                  dir_up    <= next_up;
                  ball_col  <= next_col;
                  dir_right <= next_right;
                  if (miss_left || miss_right) begin
                     state       <= ST_SCORED;
                     point_pulse <= 1'b1;
                     serve_cnt   <= '0;
                  end
               end
            end
            ST_SCORED: begin
               if (tick) begin
                  if (win_left || win_right) begin
                     state <= ST_OVER;
                  end else if (serve) begin
                     ball_row  <= CENTRE_ROW;
                     ball_col  <= CENTRE_COL;
                     dir_up    <= DIR_UP;
                     dir_right <= (ball_col == RIGHT_COL) ? DIR_RIGHT : DIR_LEFT;
                     state     <= ST_PLAY;
                  end else begin
                     serve_cnt <= serve_cnt + 4'd1;
                  end
               end
            end
            ST_OVER: begin
               if (start) begin
                  ball_row  <= CENTRE_ROW;
                  ball_col  <= CENTRE_COL;
                  dir_up    <= DIR_UP;
                  dir_right <= DIR_RIGHT;
                  state     <= ST_PLAY;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_left (
      .clk   (clk),
      .reset (reset),
      .inc   (step_play && miss_right),
      .clr   (restart),
      .score (score_left),
      .win   (win_left)
   );

   score_counter #(.WIN_SCORE(WIN_SCORE)) u_score_right (
      .clk   (clk),
      .reset (reset),
      .inc   (step_play && miss_left),
      .clr   (restart),
      .score (score_right),
      .win   (win_right)
   );

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: directed rallies with hand-traced ball positions,
// expected outputs queued by the stimulus and compared by an independent monitor.
module tb_ball_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic        start;
   logic [31:0] left_paddle;
   logic [31:0] right_paddle;
   logic [4:0]  ball_row;
   logic [5:0]  ball_col;
   logic        dir_up;
   logic        dir_right;
   logic [3:0]  score_left;
   logic [3:0]  score_right;
   logic        point_pulse;
   logic        game_over;

   typedef struct {
      string      name;
      logic [4:0] row;
      logic [5:0] col;
      logic       up;
      logic       right;
      logic [3:0] sl;
      logic [3:0] sr;
      logic       pulse;
      logic       over;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ball_engine dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .start        (start),
      .left_paddle  (left_paddle),
      .right_paddle (right_paddle),
      .ball_row     (ball_row),
      .ball_col     (ball_col),
      .dir_up       (dir_up),
      .dir_right    (dir_right),
      .score_left   (score_left),
      .score_right  (score_right),
      .point_pulse  (point_pulse),
      .game_over    (game_over)
   );

   // Each game step is a one-cycle tick; outputs settle before the next negedge.
   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         @(posedge clk);
         #1 tick = 1'b0;
      end
   endtask

   task automatic checkOutput(input string name, input int row, input int col,
                              input int up, input int right, input int sl, input int sr,
                              input int pulse, input int over);
      exp_t e;
      e.name  = name;
      e.row   = 5'(row);
      e.col   = 6'(col);
      e.up    = 1'(up);
      e.right = 1'(right);
      e.sl    = 4'(sl);
      e.sr    = 4'(sr);
      e.pulse = 1'(pulse);
      e.over  = 1'(over);
      exp_q.push_back(e);
   endtask

   task automatic pressStart();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({ball_row, ball_col, dir_up, dir_right, score_left, score_right, point_pulse, game_over}
             !== {mon_e.row, mon_e.col, mon_e.up, mon_e.right, mon_e.sl, mon_e.sr, mon_e.pulse, mon_e.over}) begin
            errors++;
            $display("[TB] FAIL %s: got row=%0d col=%0d up=%0b right=%0b score=%0d/%0d pulse=%0b over=%0b, want row=%0d col=%0d up=%0b right=%0b score=%0d/%0d pulse=%0b over=%0b",
                     mon_e.name, ball_row, ball_col, dir_up, dir_right, score_left, score_right,
                     point_pulse, game_over, mon_e.row, mon_e.col, mon_e.up, mon_e.right,
                     mon_e.sl, mon_e.sr, mon_e.pulse, mon_e.over);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b0;
      tick         = 1'b0;
      start        = 1'b0;
      left_paddle  = '1;
      right_paddle = '1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      checkOutput("reset", 16, 32, 1, 1, 0, 0, 0, 0);
      applyStimulus(1);
      checkOutput("idle_tick", 16, 32, 1, 1, 0, 0, 0, 0);

      pressStart();
      checkOutput("start", 16, 32, 1, 1, 0, 0, 0, 0);
      applyStimulus(5);
      checkOutput("run5", 21, 37, 1, 1, 0, 0, 0, 0);
      applyStimulus(10);
      checkOutput("row31", 31, 47, 1, 1, 0, 0, 0, 0);
      applyStimulus(1);
      checkOutput("top_wall", 30, 48, 0, 1, 0, 0, 0, 0);
      applyStimulus(14);
      checkOutput("at_right", 16, 62, 0, 1, 0, 0, 0, 0);
      right_paddle = 32'h0000_8000;
      applyStimulus(1);
      right_paddle = '1;
      checkOutput("right_hit", 15, 61, 0, 0, 0, 0, 0, 0);
      applyStimulus(16);
      checkOutput("bottom_wall", 1, 45, 1, 0, 0, 0, 0, 0);
      applyStimulus(44);
      checkOutput("at_left", 17, 1, 0, 0, 0, 0, 0, 0);
      left_paddle = 32'h0001_0000;
      applyStimulus(1);
      left_paddle = '1;
      checkOutput("left_hit", 16, 2, 0, 1, 0, 0, 0, 0);

      // Seven more full rallies walk the ball into the top-left corner.
      applyStimulus(853);
      checkOutput("corner_pre", 31, 1, 1, 0, 0, 0, 0, 0);
      left_paddle = 32'h4000_0000;
      applyStimulus(1);
      left_paddle = '1;
      checkOutput("corner_flip", 30, 2, 0, 1, 0, 0, 0, 0);
      applyStimulus(60);
      checkOutput("right_edge", 30, 62, 1, 1, 0, 0, 0, 0);
      right_paddle = 32'h8000_0000;
      applyStimulus(1);
      right_paddle = '1;
      checkOutput("right_hit_top", 31, 61, 1, 0, 0, 0, 0, 0);
      applyStimulus(60);
      checkOutput("pre_miss", 29, 1, 1, 0, 0, 0, 0, 0);

      left_paddle = 32'hBFFF_FFFF;
      applyStimulus(1);
      checkOutput("miss", 30, 0, 1, 0, 0, 1, 1, 0);
      idleCycle();
      checkOutput("pulse_drop", 30, 0, 1, 0, 0, 1, 0, 0);
      applyStimulus(3);
      checkOutput("frozen", 30, 0, 1, 0, 0, 1, 0, 0);
      applyStimulus(1);
      checkOutput("serve", 16, 32, 1, 0, 0, 1, 0, 0);

      left_paddle = '0;
      for (int k = 2; k <= 9; k++) begin
         applyStimulus(32);
         checkOutput("miss_loop", 14, 0, 0, 0, 0, k, 1, 0);
         if (k < 9) begin
            applyStimulus(4);
            checkOutput("serve_loop", 16, 32, 1, 0, 0, k, 0, 0);
         end
      end
      applyStimulus(1);
      checkOutput("over", 14, 0, 0, 0, 0, 9, 0, 1);
      applyStimulus(3);
      checkOutput("over_frozen", 14, 0, 0, 0, 0, 9, 0, 1);

      pressStart();
      checkOutput("restart", 16, 32, 1, 1, 0, 0, 0, 0);
      left_paddle = '1;
      applyStimulus(4);
      checkOutput("replay", 20, 36, 1, 1, 0, 0, 0, 0);

      @(negedge clk);
      reset = 1'b0;
      tick  = 1'b1;
      @(posedge clk);
      #1 reset = 1'b1;
      tick = 1'b0;
      checkOutput("mid_reset", 16, 32, 1, 1, 0, 0, 0, 0);
      applyStimulus(1);
      checkOutput("idle_after_reset", 16, 32, 1, 1, 0, 0, 0, 0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         @(negedge clk);
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
         $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
         errors += exp_q.size();
         checks += exp_q.size();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Consumes the two 32-bit paddle occupancy vectors produced by the paddle stage on a 32-row x 64-column playfield.
- Advances the ball one cell per game step, reflects it off the top/bottom walls and off paddles, detects misses, and keeps per-player scores.
- Drives the ball position, score and game-state signals consumed by the display/renderer stage downstream.

Parameters:
- ROWS, 32, playfield rows; paddle bit index = row, bit 31 = top.
- COLS, 64, playfield columns; left paddle at col 0, right paddle at col COLS-1.
- SERVE_DELAY, 4, game steps the ball is frozen after a point before re-serve.
- WIN_SCORE, 9, score that ends the game.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  single-cycle game-step strobe
- start  in  1  start or restart request, sampled only in IDLE/OVER
- left_paddle  in  32  left paddle occupancy, 1 = paddle cell
- right_paddle  in  32  right paddle occupancy
- ball_row  out  5  ball row, 0..31
- ball_col  out  6  ball column, 0..63
- dir_up  out  1  1 = row increments each step
- dir_right  out  1  1 = column increments each step
- score_left  out  4  left player points
- score_right  out  4  right player points
- point_pulse  out  1  one-cycle pulse when a point is awarded
- game_over  out  1  high in OVER state

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clk.
- All state changes happen on tick cycles only, except start handling (any cycle) and reset.
- Reset (reset==0 at posedge):
  - state=IDLE, ball_row=16, ball_col=32, dir_up=1, dir_right=1.
  - score_left=0, score_right=0, point_pulse=0, game_over=0.
  - Reset overrides tick and start in the same cycle; mid-game reset aborts immediately.
- IDLE: ball held at centre. On start=1, go to PLAY on the next cycle.
- PLAY, on each step:
  - Vertical:
    - If dir_up=1 and row=31: dir_up<=0, row<=30.
    - If dir_up=0 and row=0: dir_up<=1, row<=1.
    - Otherwise row moves ±1.
  - Horizontal: compute from the new row (nrow) in the same step.
    - col=1, dir_right=0: if left_paddle[nrow]=1, dir_right<=1 and col<=2. Else col<=0, score_right+1, go to SCORED.
    - col=62, dir_right=1: if right_paddle[nrow]=1, dir_right<=0 and col<=61. Else col<=63, score_left+1, go to SCORED.
    - Otherwise col moves ±1.
  - A wall reflection and a paddle hit in the same step both apply.
- SCORED:
  - point_pulse=1 for exactly the cycle after entry.
  - If the new score equals WIN_SCORE, go to OVER.
  - Otherwise count SERVE_DELAY steps with the ball frozen at col 0/63, then:
    - ball_row=16, ball_col=32, dir_up=1;
    - dir_right points toward the player who conceded (conceder serves-receives);
    - go to PLAY.
- OVER: game_over=1, ball frozen. start=1 clears both scores, centres the ball and goes to PLAY.
- Scores saturate at 15 and never wrap. WIN_SCORE must be ≤15.
- Paddle vectors are sampled combinationally on the step cycle; no internal registering.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- Defined:
  - A 2-bit rally counter increments on each paddle hit and clears on a point.
  - While the counter <3, the ball advances only on every 2nd tick (internal phase bit, cleared on serve).
  - At 3, the ball advances on every tick.
- Not defined: the ball advances on every tick; no counter or phase bit exists.

Decomposition:
- pong_pkg:
  - ROWS, COLS, CENTRE_ROW=16, CENTRE_COL=32;
  - LEFT_COL=0, RIGHT_COL=63;
  - state enum {IDLE, PLAY, SCORED, OVER};
  - direction constants.
- Sub-module score_counter: 4-bit saturating counter with inc, clr and WIN_SCORE compare. Instanced twice.
- Motion, collision and the FSM stay in ball_engine.

Test Plan:
- Reset held 2 cycles, then released -> row=16, col=32, score 0/0, IDLE. A tick without start -> no movement.
- start, then 5 ticks (macro off) -> row=21, col=37, dir_up=1, dir_right=1.
- Ball row=31, col=10, dir_up=1, tick -> row=30, dir_up=0, col=11.
- Ball row=5, col=1, dir_right=0, dir_up=0, left_paddle=0x000000F0, tick -> nrow=4 is a hit: col=2, dir_right=1. Repeat with left_paddle=0x00000F00 -> col=0, score_right=1, point_pulse one cycle, re-serve after 4 ticks at (16,32) with dir_right=0.
- Corner case: row=0, col=62, dir_up=0, dir_right=1, right_paddle bit1=1 -> row=1, col=61, both directions flip in the same step.
- score_left=8, left wins a point -> OVER, game_over=1, ticks ignored. start -> scores 0/0, PLAY. Reset mid-PLAY -> IDLE at centre on the next cycle.
